pio_in_edge_irq: RTL and testbench
==================================

# pio_in_edge_irq

Parametrised Avalon-MM input PIO for the HPS lightweight bridge: samples a WIDTH-bit external input bus (switches, keys), synchronises and optionally debounces each bit, latches selected edges into a sticky capture register and raises a maskable level interrupt. It is the next-generation replacement for the plain data-only input port: same register-0 read semantics and read latency, plus edge capture and IRQ.

## Interface
Parameters:
- WIDTH, 10, number of input bits; legal range 1..32.
- EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any.
- DEBOUNCE_CYCLES, 0, consecutive cycles a synchronised bit must differ from its stable value before the stable value updates; 0 and 1 both mean no debounce.

Ports:
- clk  input  1  system clock; single clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  2  Avalon word address.
- chipselect  input  1  Avalon slave select.
- write_n  input  1  active-low write strobe; write occurs when chipselect=1 and write_n=0.
- writedata  input  32  Avalon write data; bits above WIDTH-1 ignored.
- in_port  input  WIDTH  asynchronous external inputs.
- readdata  output  32  registered read data; bits above WIDTH-1 always 0.
- irq  output  1  level interrupt, high while any unmasked capture bit is set.

## Operation
- Register map: 0 data (RO, stable input values; writes ignored); 1 irqmask (RW); 2 edgecapture (R, write-1-to-clear per bit); 3 reserved (reads 0, writes ignored).
- Per bit: two-flop synchroniser sync1→sync2, then stable register.
- Debounce (DEBOUNCE_CYCLES=N≥2): per-bit counter, width clog2(N+1). While sync2≠stable, counter increments each cycle; when counter==N-1 and sync2 still ≠ stable, stable←sync2 and counter←0. Any cycle with sync2==stable clears counter. N≤1: stable←sync2 every cycle.
- Edge detect on the stable update: rising = stable 0→1, falling = 1→0, any = either. Detected edge sets edgecapture bit in the same cycle stable updates.
- Set/clear collision: write-1-to-clear and a new edge on the same bit in the same cycle → bit ends set (set wins).
- irq = |(edgecapture & irqmask), driven combinationally from registers (glitch-free).
- readdata updates every cycle from address, independent of chipselect, as in the existing input port; reads have no side effects.

## Timing
- Reset: sync1, sync2, stable, counters, irqmask, edgecapture, readdata all 0; irq 0.
- An input held high through reset appears as a 0→1 transition after reset and is captured if EDGE_TYPE is 0 or 2 (documented, not suppressed).
- in_port change settled before edge k, N≤1: sync1 at k, sync2 at k+1, stable and edgecapture at k+2, irq high after k+2, readdata (address 0 or 2) at k+3.
- With N≥2: stable/edgecapture update at edge k+1+N; glitches shorter than N cycles at sync2 never reach stable.
- Register write takes effect at the write clock edge; readdata reflects it on the following edge. irq falls the cycle after a clearing write or mask write.
- Read latency: 1 cycle (address sampled at edge e, data valid after e).
- Reset asserted mid-debounce or with capture pending: all state cleared immediately, irq drops asynchronously.

## Test plan
- Reset/data: WIDTH=10, N=0; hold in_port=10'h2A5 through reset release; address 0 → readdata 32'h000002A5 from 3 cycles after release, upper 22 bits 0; address 3 → 0.
- Rising capture + IRQ: EDGE_TYPE=0, mask=10'h001 written at address 1; toggle in_port[0] 0→1 → edgecapture bit0=1 and irq=1 exactly 2 edges later; write 32'h1 to address 2 → irq=0 next cycle, readback 0.
- Masking/falling/any: EDGE_TYPE=1, mask=0; bit3 1→0 → capture bit3=1, irq stays 0; write mask 10'h008 → irq=1 next cycle. EDGE_TYPE=2: bit3 pulse → bit3 set on either edge.
- Debounce: N=4; 3-cycle glitch on bit5 → stable and capture unchanged; 6-cycle high level → stable bit5=1 at edge k+5, capture set.
- Set/clear collision: arrange bit2 edge on the same cycle as a write of 32'h4 to address 2 → bit2 remains 1, irq stays high if masked.
- Reset mid-operation: assert reset_n low with capture=10'h3FF and mask=10'h3FF → irq and readdata 0 immediately; after release capture reads 0 until new edges.

Source files
------------

// File: rtl/pio_in_edge_irq.sv
// Input PIO: synchronise, optionally debounce, latch selected edges and raise a maskable level irq.
// Latency: stable/edgecapture 2 edges after in_port settles (N+1 with debounce); readdata 1 cycle after address.
// Backpressure: none; the Avalon slave has no wait states and accepts every write in its own cycle.
module pio_in_edge_irq #(
    parameter int WIDTH           = 10,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = (DEBOUNCE_CYCLES >= 2) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             wr_en;

    // Bits of writedata above WIDTH are don't-care; fold them into a sink.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en = chipselect & ~write_n;

    // Two-flop synchroniser for the asynchronous external inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync2_d_of(sync1_q);
        end
    end

    function automatic logic [WIDTH-1:0] sync2_d_of(input logic [WIDTH-1:0] v);
        return v;
    endfunction

    generate
        if (DEBOUNCE_CYCLES >= 2) begin : g_db
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0] cnt_q [WIDTH];
            logic [CW-1:0] cnt_d [WIDTH];

            // Per-bit run-length counter: stable follows sync2 only after N consecutive differing cycles.
            always_comb begin
                for (int b = 0; b < WIDTH; b++) begin
                    cnt_d[b]    = '0;
                    stable_d[b] = stable_q[b];
                    if (sync2_q[b] != stable_q[b]) begin
                        if (cnt_q[b] == LAST) begin
                            stable_d[b] = sync2_q[b];
                        end else begin
                            cnt_d[b] = cnt_q[b] + 1'b1;
                        end
                    end
                end
            end

            // Debounce counter registers.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int b = 0; b < WIDTH; b++) cnt_q[b] <= '0;
                end else begin
                    for (int b = 0; b < WIDTH; b++) cnt_q[b] <= cnt_d[b];
                end
            end
        end else begin : g_nodb
            assign stable_d = sync2_q;
        end
    endgenerate

    assign rise = stable_d & ~stable_q;
    assign fall = ~stable_d & stable_q;

    // Select which stable-value transitions are latched.
    always_comb begin
        case (EDGE_TYPE)
            0:       edge_set = rise;
            1:       edge_set = fall;
            default: edge_set = rise | fall;
        endcase
    end

    // Register writes: mask load and write-1-to-clear capture; a new edge beats a clear.
    always_comb begin
        irqmask_d = irqmask_q;
        edge_clr  = '0;
        if (wr_en && address == 2'd1) irqmask_d = writedata[WIDTH-1:0];
        if (wr_en && address == 2'd2) edge_clr  = writedata[WIDTH-1:0];
        edgecap_d = (edgecap_q & ~edge_clr) | edge_set;
    end

    // Read mux sampled every cycle regardless of chipselect; reads have no side effects.
    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = stable_q;
            2'd1:    readdata_d[WIDTH-1:0] = irqmask_q;
            2'd2:    readdata_d[WIDTH-1:0] = edgecap_q;
            default: readdata_d = '0;
        endcase
    end

    // Stable value, control registers and registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q   <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            stable_q   <= stable_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: four instances (rising, falling, any, rising+debounce 4) share one bus.
// Latency: checks sample on the falling edge, half a cycle after each active edge.
// Backpressure: none; stimulus is applied on the falling edge and consumed at the next rising edge.
module tb_pio_in_edge_irq;

    localparam int W = 10;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b0;
    logic [1:0]    address    = 2'd0;
    logic          chipselect = 1'b0;
    logic          write_n    = 1'b1;
    logic [31:0]   writedata  = '0;
    logic [W-1:0]  in_port    = '0;
    logic [31:0]   rd_o  [4];
    logic          irq_o [4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pio_in_edge_irq #(.WIDTH(W), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0)) u_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_o[0]), .irq(irq_o[0]));
    pio_in_edge_irq #(.WIDTH(W), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_o[1]), .irq(irq_o[1]));
    pio_in_edge_irq #(.WIDTH(W), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(0)) u_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_o[2]), .irq(irq_o[2]));
    pio_in_edge_irq #(.WIDTH(W), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4)) u_deb (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_o[3]), .irq(irq_o[3]));

    // Reference model: per-instance edge type and effective debounce window.
    int et_m [4] = '{0, 1, 2, 0};
    int nb_m [4] = '{1, 1, 1, 4};

    logic [W-1:0] m_stab [4];
    logic [W-1:0] m_cap  [4];
    logic [W-1:0] m_mask [4];
    logic [31:0]  m_rd   [4];
    logic [W-1:0] hist   [8];   // hist[j] = in_port sampled j+1 edges before the next edge
    logic [W-1:0] mclr, mns, mset;
    bit           agree;

    // A stable bit takes the synchronised value once the last N synchronised samples all disagree with it.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                m_stab[i] = '0; m_cap[i] = '0; m_mask[i] = '0; m_rd[i] = '0;
            end
            for (int j = 0; j < 8; j++) hist[j] = '0;
        end else begin
            mclr = (chipselect && !write_n && address == 2'd2) ? writedata[W-1:0] : '0;
            for (int i = 0; i < 4; i++) begin
                case (address)
                    2'd0:    m_rd[i] = {{(32-W){1'b0}}, m_stab[i]};
                    2'd1:    m_rd[i] = {{(32-W){1'b0}}, m_mask[i]};
                    2'd2:    m_rd[i] = {{(32-W){1'b0}}, m_cap[i]};
                    default: m_rd[i] = '0;
                endcase
                mns = m_stab[i];
                for (int b = 0; b < W; b++) begin
                    agree = 1'b1;
                    for (int j = 1; j <= nb_m[i]; j++)
                        if (hist[j][b] == m_stab[i][b]) agree = 1'b0;
                    if (agree) mns[b] = hist[1][b];
                end
                if (et_m[i] == 0)      mset = mns & ~m_stab[i];
                else if (et_m[i] == 1) mset = ~mns & m_stab[i];
                else                   mset = mns ^ m_stab[i];
                m_cap[i] = (m_cap[i] & ~mclr) | mset;
                if (chipselect && !write_n && address == 2'd1) m_mask[i] = writedata[W-1:0];
                m_stab[i] = mns;
            end
            for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = in_port;
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle(input int n);
        repeat (n) step();
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_port = 10'h2A5; address = 2'd0;
        settle(2);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_o[i] !== 32'd0 || irq_o[i] !== 1'b0) begin
                n_bad++; $display("FAIL reset_state[%0d]: rd=%h irq=%b want 0/0", i, rd_o[i], irq_o[i]);
            end
        end
        reset_n = 1'b1;
        repeat (8) begin
            step();
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (rd_o[i] !== m_rd[i]) begin n_bad++; $display("FAIL reset_model_rd[%0d]: got %h want %h", i, rd_o[i], m_rd[i]); end
            end
        end
        n_cmp++;
        if (rd_o[0] !== 32'h0000_02A5) begin n_bad++; $display("FAIL reset_data: got %h want 000002a5", rd_o[0]); end
        n_cmp++;
        if (rd_o[3] !== 32'h0000_02A5) begin n_bad++; $display("FAIL reset_data_deb: got %h want 000002a5", rd_o[3]); end
        address = 2'd3;
        step();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_o[i] !== 32'd0) begin n_bad++; $display("FAIL reserved_read[%0d]: got %h want 0", i, rd_o[i]); end
        end
    endtask

    task automatic test_rising();
        in_port = '0; settle(8);
        bus_wr(2'd2, 32'h3FF); bus_wr(2'd1, 32'h001); address = 2'd2;
        step();
        in_port[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (rd_o[i] !== m_rd[i] || irq_o[i] !== |(m_cap[i] & m_mask[i])) begin
                    n_bad++; $display("FAIL rise_model[%0d]: rd=%h irq=%b want %h %b", i, rd_o[i], irq_o[i], m_rd[i], |(m_cap[i] & m_mask[i]));
                end
            end
            if (c == 1) begin
                n_cmp++;
                if (irq_o[0] !== 1'b0) begin n_bad++; $display("FAIL rise_irq_early: got %b want 0", irq_o[0]); end
            end
            if (c == 2) begin
                n_cmp++;
                if (irq_o[0] !== 1'b1) begin n_bad++; $display("FAIL rise_irq: got %b want 1", irq_o[0]); end
            end
            if (c == 3) begin
                n_cmp++;
                if (rd_o[0] !== 32'h1) begin n_bad++; $display("FAIL rise_cap: got %h want 1", rd_o[0]); end
            end
        end
        bus_wr(2'd2, 32'h1);
        n_cmp++;
        if (irq_o[0] !== 1'b0) begin n_bad++; $display("FAIL rise_clear_irq: got %b want 0", irq_o[0]); end
        step();
        n_cmp++;
        if (rd_o[0] !== 32'h0) begin n_bad++; $display("FAIL rise_clear_rd: got %h want 0", rd_o[0]); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_o[i] !== m_rd[i] || irq_o[i] !== |(m_cap[i] & m_mask[i])) begin
                n_bad++; $display("FAIL rise_clear_model[%0d]: rd=%h irq=%b want %h", i, rd_o[i], irq_o[i], m_rd[i]);
            end
        end
    endtask

    task automatic test_mask_fall_any();
        bus_wr(2'd1, 32'h0); in_port = 10'h008; settle(8);
        bus_wr(2'd2, 32'h3FF); address = 2'd2; step();
        in_port = '0;
        settle(4);
        n_cmp++;
        if (rd_o[1] !== 32'h8 || irq_o[1] !== 1'b0) begin
            n_bad++; $display("FAIL fall_masked: rd=%h irq=%b want 00000008 0", rd_o[1], irq_o[1]);
        end
        bus_wr(2'd1, 32'h008);
        n_cmp++;
        if (irq_o[1] !== 1'b1) begin n_bad++; $display("FAIL fall_unmask_irq: got %b want 1", irq_o[1]); end
        bus_wr(2'd2, 32'h3FF); address = 2'd2;
        in_port = 10'h008;
        settle(4);
        n_cmp++;
        if (rd_o[2] !== 32'h8 || rd_o[1] !== 32'h0) begin
            n_bad++; $display("FAIL any_rise: any=%h fall=%h want 8 0", rd_o[2], rd_o[1]);
        end
        bus_wr(2'd2, 32'h3FF); address = 2'd2;
        in_port = '0;
        settle(4);
        n_cmp++;
        if (rd_o[2] !== 32'h8 || rd_o[1] !== 32'h8) begin
            n_bad++; $display("FAIL any_fall: any=%h fall=%h want 8 8", rd_o[2], rd_o[1]);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_o[i] !== m_rd[i] || irq_o[i] !== |(m_cap[i] & m_mask[i])) begin
                n_bad++; $display("FAIL maskany_model[%0d]: rd=%h irq=%b want %h", i, rd_o[i], irq_o[i], m_rd[i]);
            end
        end
    endtask

    task automatic test_debounce();
        settle(8); bus_wr(2'd2, 32'h3FF); address = 2'd2;
        in_port[5] = 1'b1; settle(3); in_port[5] = 1'b0;
        settle(8);
        n_cmp++;
        if (rd_o[3] !== 32'h0) begin n_bad++; $display("FAIL deb_glitch_cap: got %h want 0", rd_o[3]); end
        n_cmp++;
        if (rd_o[0] !== 32'h20) begin n_bad++; $display("FAIL nodeb_glitch_cap: got %h want 20", rd_o[0]); end
        address = 2'd0; step();
        in_port[5] = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (rd_o[i] !== m_rd[i]) begin n_bad++; $display("FAIL deb_model[%0d]: got %h want %h", i, rd_o[i], m_rd[i]); end
            end
            if (c == 6) begin
                n_cmp++;
                if (rd_o[3][5] !== 1'b0) begin n_bad++; $display("FAIL deb_early: got %b want 0", rd_o[3][5]); end
                in_port[5] = 1'b0;
            end
        end
        n_cmp++;
        if (rd_o[3] !== 32'h20) begin n_bad++; $display("FAIL deb_stable: got %h want 20", rd_o[3]); end
        address = 2'd2; step();
        n_cmp++;
        if (rd_o[3] !== 32'h20) begin n_bad++; $display("FAIL deb_cap: got %h want 20", rd_o[3]); end
    endtask

    task automatic test_collision();
        bus_wr(2'd1, 32'h3FF); in_port = '0; settle(8);
        bus_wr(2'd2, 32'h3FF); address = 2'd2;
        in_port[2] = 1'b1;
        settle(2);
        chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'h4;
        step();
        chipselect = 1'b0; write_n = 1'b1;
        n_cmp++;
        if (irq_o[0] !== 1'b1) begin n_bad++; $display("FAIL collide_irq: got %b want 1", irq_o[0]); end
        step();
        n_cmp++;
        if (rd_o[0] !== 32'h4) begin n_bad++; $display("FAIL collide_cap: got %h want 4", rd_o[0]); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_o[i] !== m_rd[i] || irq_o[i] !== |(m_cap[i] & m_mask[i])) begin
                n_bad++; $display("FAIL collide_model[%0d]: rd=%h irq=%b want %h", i, rd_o[i], irq_o[i], m_rd[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) in_port = W'($urandom);
            else if ($urandom_range(0, 9) == 0) in_port[$urandom_range(0, W-1)] ^= 1'b1;
            address = 2'($urandom_range(0, 3));
            writedata = $urandom;
            chipselect = 1'($urandom_range(0, 1));
            write_n = ($urandom_range(0, 5) != 0);
            step();
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (rd_o[i] !== m_rd[i] || irq_o[i] !== |(m_cap[i] & m_mask[i])) begin
                    n_bad++; $display("FAIL random[%0d] c=%0d: rd=%h irq=%b want %h %b", i, c, rd_o[i], irq_o[i], m_rd[i], |(m_cap[i] & m_mask[i]));
                end
            end
        end
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        bus_wr(2'd1, 32'h3FF);
        in_port = 10'h3FF; settle(4);
        in_port = '0; settle(4);
        address = 2'd2; step();
        n_cmp++;
        if (irq_o[2] !== 1'b1 || rd_o[2] !== 32'h3FF) begin
            n_bad++; $display("FAIL pre_reset: irq=%b rd=%h want 1 3ff", irq_o[2], rd_o[2]);
        end
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (irq_o[i] !== 1'b0 || rd_o[i] !== 32'd0) begin
                n_bad++; $display("FAIL reset_async[%0d]: irq=%b rd=%h want 0 0", i, irq_o[i], rd_o[i]);
            end
        end
        @(negedge clk);
        reset_n = 1'b1; address = 2'd2;
        settle(6);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd_o[i] !== 32'd0 || irq_o[i] !== 1'b0) begin
                n_bad++; $display("FAIL post_reset_cap[%0d]: rd=%h irq=%b want 0 0", i, rd_o[i], irq_o[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_mask_fall_any();
        test_debounce();
        test_collision();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
